fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the controller/main decoder.
- Owns the program counter and issues requests to a variable-latency instruction memory over a req/valid handshake.
- Holds the fetched instruction stable for decode/execute until acknowledged.
- Selects the next PC from the redirect signals the decoder produces: Branch, Jump and Jalr.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/valid handshake, holds
// the instruction for decode until acknowledged and applies Branch/Jump/Jalr redirects.
module fetch_unit #(
    parameter int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] Instr,
    output logic            instr_valid,
    input  logic            instr_ack,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            Jalr,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    output logic            misalign
);

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] instrNext;
    logic [XLEN-1:0] redirectPc;

    // Redirect target; only consumed in the HOLD+ack cycle, so X elsewhere never reaches PC.
    always_comb begin
        redirectPc = PC + PC_STEP;
        if (Jalr) begin
            redirectPc = ALUResult & ~XLEN'(1);
        end else if (Jump || Branch) begin
            redirectPc = PCTarget;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = PC;
        instrNext = Instr;
        case (state)
            IDLE: begin
                stateNext = REQ;
            end
            REQ: begin
                if (imem_valid) begin
                    stateNext = HOLD;
                    instrNext = imem_rdata;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    if (redirectPc[1:0] == 2'b00) begin
                        stateNext = REQ;
                        pcNext    = redirectPc;
                    end else begin
                        stateNext = FAULT;
                    end
                end
            end
            FAULT: begin
                stateNext = FAULT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            PCPlus4     <= RESET_PC + PC_STEP;
            Instr       <= NOP_INSTR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state       <= stateNext;
            PC          <= pcNext;
            PCPlus4     <= pcNext + PC_STEP;
            Instr       <= instrNext;
            imem_req    <= (stateNext == REQ);
            instr_valid <= (stateNext == HOLD);
            misalign    <= misalign | (stateNext == FAULT);
        end
    end

    assign imem_addr = PC;

endmodule
